// File: rtl/types_pkg.sv
// Shared datapath types: word type, ALU opcodes and arbiter-wide constants.
package types_pkg;

    localparam int WORD_W          = 32;
    localparam int SHIFT_AMOUNT    = 5;
    localparam int ALU_ARB_MAX_REQ = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU; undefined opcodes yield 0, which raises zero.
module alu
    import types_pkg::*;
(
    input  aluop_e control,
    input  word_t  a,
    input  word_t  b,
    output word_t  result,
    output logic   zero
);

    word_t result_s;

    // operation select
    always_comb begin
        result_s = '0;
        case (control)
            ALU_ADD:  result_s = a + b;
            ALU_SUB:  result_s = a - b;
            ALU_AND:  result_s = a & b;
            ALU_OR:   result_s = a | b;
            ALU_XOR:  result_s = a ^ b;
            ALU_SLL:  result_s = a << b[SHIFT_AMOUNT-1:0];
            ALU_SRL:  result_s = a >> b[SHIFT_AMOUNT-1:0];
            ALU_SRA:  result_s = word_t'($signed(a) >>> b[SHIFT_AMOUNT-1:0]);
            ALU_SLT:  result_s = {{(WORD_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result_s = {{(WORD_W-1){1'b0}}, (a < b)};
            default:  result_s = '0;
        endcase
    end

    assign result = result_s;
    assign zero   = (result_s == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters, with a one-entry
// result register that is held until its owner accepts it.
module alu_arbiter
    import types_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  aluop_e             req_op [NUM_REQ],
    input  word_t              req_a  [NUM_REQ],
    input  word_t              req_b  [NUM_REQ],
    output logic [NUM_REQ-1:0] rsp_valid,
    input  logic [NUM_REQ-1:0] rsp_ready,
    output word_t              rsp_result,
    output logic               rsp_zero,
    output logic [ID_W-1:0]    rsp_id,
    output logic               busy
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, map it back.
    // Result is {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic [NUM_REQ-1:0] rot;
        logic [ID_W-1:0]    src;
        logic               found;
        logic [ID_W-1:0]    idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            src    = ID_W'((int'(ptr) + k) % NUM_REQ);
            rot[k] = valid[src];
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                idx   = ID_W'((int'(ptr) + k) % NUM_REQ);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    word_t           rsp_result_q, rsp_result_d;
    logic            rsp_zero_q, rsp_zero_d;

    logic [ID_W:0]   pick_s;
    logic [ID_W-1:0] grant_id_s;
    logic            any_valid_s;
    logic            slot_free_s;
    logic            xfer_s;
    aluop_e          alu_op_s;
    word_t           alu_a_s, alu_b_s, alu_result_s;
    logic            alu_zero_s;

    assign pick_s      = rr_pick(req_valid, rr_ptr_q);
    assign any_valid_s = pick_s[ID_W];
    assign grant_id_s  = pick_s[ID_W-1:0];

    // Slot availability, grant decode and operand mux toward the shared ALU
    always_comb begin
        slot_free_s = (state_q == ST_EMPTY) || rsp_ready[rsp_id_q];
        xfer_s      = rst_n && slot_free_s && any_valid_s;
        alu_op_s    = req_op[grant_id_s];
        alu_a_s     = req_a[grant_id_s];
        alu_b_s     = req_b[grant_id_s];
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = xfer_s && (grant_id_s == ID_W'(i));
        end
    end

    alu u_alu (
        .control (alu_op_s),
        .a       (alu_a_s),
        .b       (alu_b_s),
        .result  (alu_result_s),
        .zero    (alu_zero_s)
    );

    // Next state: a transfer (re)loads the register, otherwise the owner may drain it
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        if (xfer_s) begin
            state_d      = ST_FULL;
            rsp_id_d     = grant_id_s;
            rsp_result_d = alu_result_s;
            rsp_zero_d   = alu_zero_s;
            rr_ptr_d     = (grant_id_s == LAST_ID) ? '0 : grant_id_s + ID_W'(1);
        end else if ((state_q == ST_FULL) && rsp_ready[rsp_id_q]) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // State, pointer and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            rr_ptr_q     <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    // Owner decode of the held result
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (state_q == ST_FULL) && (rsp_id_q == ID_W'(i));
        end
    end

    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = (state_q == ST_FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scenario tests plus a randomized run against a behavioural model, on a
// two-requester and a three-requester instance.
module tb_alu_arbiter;
    import types_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] v2, rdy2, rspv2, rr2;
    aluop_e     op2 [2];
    word_t      a2 [2], b2 [2];
    word_t      res2;
    logic       zero2, busy2;
    logic [0:0] id2;

    logic [2:0] v3, rdy3, rspv3, rr3;
    aluop_e     op3 [3];
    word_t      a3 [3], b3 [3];
    word_t      res3;
    logic       zero3, busy3;
    logic [1:0] id3;

    alu_arbiter #(.NUM_REQ(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2),
        .req_op(op2), .req_a(a2), .req_b(b2), .rsp_valid(rspv2),
        .rsp_ready(rr2), .rsp_result(res2), .rsp_zero(zero2),
        .rsp_id(id2), .busy(busy2)
    );

    alu_arbiter #(.NUM_REQ(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3),
        .req_op(op3), .req_a(a3), .req_b(b3), .rsp_valid(rspv3),
        .rsp_ready(rr3), .rsp_result(res3), .rsp_zero(zero3),
        .rsp_id(id3), .busy(busy3)
    );

    int n_pass = 0;
    int n_total = 0;

    // behavioural model state for dut2
    bit    m_full;
    int    m_id, m_ptr;
    word_t m_res;

    function automatic word_t ref_alu(input int op, input word_t a, input word_t b);
        logic [63:0] ext;
        int sh;
        sh = int'(b % 32);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << sh;
            6: return a >> sh;
            7: begin
                ext = {{32{a[31]}}, a} >> sh;
                return ext[31:0];
            end
            8: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // which requester the model grants this cycle, -1 if none
    function automatic int model_grant(input logic [1:0] v, input logic [1:0] rr);
        int idx;
        if (m_full && !rr[m_id]) return -1;
        for (int k = 0; k < 2; k++) begin
            idx = (m_ptr + k) % 2;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        v2 = 2'b00; rr2 = 2'b00; v3 = 3'b000; rr3 = 3'b000;
        for (int i = 0; i < 2; i++) begin op2[i] = ALU_ADD; a2[i] = 32'd0; b2[i] = 32'd0; end
        for (int i = 0; i < 3; i++) begin op3[i] = ALU_ADD; a3[i] = 32'd0; b3[i] = 32'd0; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        v2 = 2'b11; rr2 = 2'b11; v3 = 3'b111;
        @(negedge clk); @(negedge clk);
        #1;
        n_total++; if (rdy2 !== 2'b00) $display("FAIL reset_req_ready got %b want 00", rdy2); else n_pass++;
        n_total++; if (rspv2 !== 2'b00) $display("FAIL reset_rsp_valid got %b want 00", rspv2); else n_pass++;
        n_total++; if (res2 !== 32'd0) $display("FAIL reset_result got %h want 0", res2); else n_pass++;
        n_total++; if (zero2 !== 1'b0) $display("FAIL reset_zero got %b want 0", zero2); else n_pass++;
        n_total++; if (id2 !== 1'b0) $display("FAIL reset_id got %0d want 0", id2); else n_pass++;
        n_total++; if (busy2 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy2); else n_pass++;
        n_total++; if (rdy3 !== 3'b000) $display("FAIL reset_req_ready3 got %b want 000", rdy3); else n_pass++;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        v2 = 2'b01; op2[0] = ALU_ADD; a2[0] = 32'd5; b2[0] = 32'd7; rr2 = 2'b11;
        #1;
        n_total++; if (rdy2 !== 2'b01) $display("FAIL add_req_ready got %b want 01", rdy2); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rspv2 !== 2'b01) $display("FAIL add_rsp_valid got %b want 01", rspv2); else n_pass++;
        n_total++; if (res2 !== 32'd12) $display("FAIL add_result got %0d want 12", res2); else n_pass++;
        n_total++; if (zero2 !== 1'b0) $display("FAIL add_zero got %b want 0", zero2); else n_pass++;
        n_total++; if (id2 !== 1'b0) $display("FAIL add_id got %0d want 0", id2); else n_pass++;
        n_total++; if (busy2 !== 1'b1) $display("FAIL add_busy got %b want 1", busy2); else n_pass++;
        @(negedge clk);
        v2 = 2'b00;
        @(posedge clk); #1;
        n_total++; if (busy2 !== 1'b0) $display("FAIL add_drain_busy got %b want 0", busy2); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int e;
        do_reset();
        v2 = 2'b11; rr2 = 2'b11;
        op2[0] = ALU_SUB; a2[0] = 32'd3; b2[0] = 32'd3;
        op2[1] = ALU_SLT; a2[1] = 32'hFFFF_FFFF; b2[1] = 32'd0;
        for (int k = 0; k < 4; k++) begin
            e = k % 2;
            #1;
            n_total++; if (rdy2 !== (2'b01 << e)) $display("FAIL alt_req_ready[%0d] got %b want %b", k, rdy2, 2'b01 << e); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (rspv2 !== (2'b01 << e)) $display("FAIL alt_rsp_valid[%0d] got %b want %b", k, rspv2, 2'b01 << e); else n_pass++;
            n_total++; if (res2 !== word_t'(e)) $display("FAIL alt_result[%0d] got %0d want %0d", k, res2, e); else n_pass++;
            n_total++; if (zero2 !== (e == 0)) $display("FAIL alt_zero[%0d] got %b want %b", k, zero2, e == 0); else n_pass++;
            @(negedge clk);
        end
        v2 = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        v2 = 2'b10; op2[1] = ALU_ADD; a2[1] = 32'd1; b2[1] = 32'd2; rr2 = 2'b00;
        @(posedge clk); #1;
        n_total++; if (rspv2 !== 2'b10) $display("FAIL bp_first_valid got %b want 10", rspv2); else n_pass++;
        @(negedge clk);
        v2 = 2'b01; op2[0] = ALU_ADD; a2[0] = 32'd5; b2[0] = 32'd7;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_total++; if (rdy2 !== 2'b00) $display("FAIL bp_req_ready[%0d] got %b want 00", k, rdy2); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (busy2 !== 1'b1) $display("FAIL bp_busy[%0d] got %b want 1", k, busy2); else n_pass++;
            n_total++; if (rspv2 !== 2'b10) $display("FAIL bp_rsp_valid[%0d] got %b want 10", k, rspv2); else n_pass++;
            n_total++; if (res2 !== 32'd3) $display("FAIL bp_result[%0d] got %0d want 3", k, res2); else n_pass++;
            @(negedge clk);
        end
        rr2 = 2'b10;
        #1;
        n_total++; if (rdy2 !== 2'b01) $display("FAIL bp_release_ready got %b want 01", rdy2); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rspv2 !== 2'b01) $display("FAIL bp_reload_valid got %b want 01", rspv2); else n_pass++;
        n_total++; if (res2 !== 32'd12) $display("FAIL bp_reload_result got %0d want 12", res2); else n_pass++;
        @(negedge clk);
        v2 = 2'b00; rr2 = 2'b11;
        @(negedge clk);
    endtask

    task automatic test_foreign_ready();
        do_reset();
        v2 = 2'b01; op2[0] = ALU_ADD; a2[0] = 32'd5; b2[0] = 32'd7; rr2 = 2'b00;
        @(posedge clk);
        @(negedge clk);
        v2 = 2'b10; op2[1] = ALU_ADD; a2[1] = 32'd1; b2[1] = 32'd1; rr2 = 2'b10;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_total++; if (rdy2 !== 2'b00) $display("FAIL foreign_req_ready[%0d] got %b want 00", k, rdy2); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (busy2 !== 1'b1) $display("FAIL foreign_busy[%0d] got %b want 1", k, busy2); else n_pass++;
            n_total++; if (rspv2 !== 2'b01) $display("FAIL foreign_rsp_valid[%0d] got %b want 01", k, rspv2); else n_pass++;
            @(negedge clk);
        end
        v2 = 2'b00; rr2 = 2'b01;
        @(posedge clk); #1;
        n_total++; if (busy2 !== 1'b0) $display("FAIL foreign_drain got %b want 0", busy2); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int exp_order [4] = '{2, 0, 1, 2};
        int e;
        do_reset();
        for (int i = 0; i < 3; i++) begin op3[i] = ALU_ADD; a3[i] = word_t'(i); b3[i] = 32'd10; end
        v3 = 3'b010; rr3 = 3'b111;
        @(posedge clk);
        @(negedge clk);
        v3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            e = exp_order[k];
            #1;
            n_total++; if (rdy3 !== (3'b001 << e)) $display("FAIL wrap_req_ready[%0d] got %b want %b", k, rdy3, 3'b001 << e); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (id3 !== 2'(e)) $display("FAIL wrap_id[%0d] got %0d want %0d", k, id3, e); else n_pass++;
            n_total++; if (res3 !== word_t'(10 + e)) $display("FAIL wrap_result[%0d] got %0d want %0d", k, res3, 10 + e); else n_pass++;
            @(negedge clk);
        end
        v3 = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_full();
        do_reset();
        v2 = 2'b01; op2[0] = ALU_SRA; a2[0] = 32'h8000_0000; b2[0] = 32'd4; rr2 = 2'b00;
        @(posedge clk); #1;
        n_total++; if (res2 !== 32'hF800_0000) $display("FAIL sra_result got %h want f8000000", res2); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if (rspv2 !== 2'b00) $display("FAIL midrst_rsp_valid got %b want 00", rspv2); else n_pass++;
        n_total++; if (res2 !== 32'd0) $display("FAIL midrst_result got %h want 0", res2); else n_pass++;
        n_total++; if (busy2 !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy2); else n_pass++;
        n_total++; if (rdy2 !== 2'b00) $display("FAIL midrst_req_ready got %b want 00", rdy2); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rspv2 !== 2'b00) $display("FAIL midrst_no_grant got %b want 00", rspv2); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        v2 = 2'b11; op2[1] = ALU_ADD; a2[1] = 32'd1; b2[1] = 32'd1; rr2 = 2'b11;
        #1;
        n_total++; if (rspv2 !== 2'b00) $display("FAIL postrst_stale_valid got %b want 00", rspv2); else n_pass++;
        n_total++; if (rdy2 !== 2'b01) $display("FAIL postrst_first_grant got %b want 01", rdy2); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (id2 !== 1'b0) $display("FAIL postrst_id got %0d want 0", id2); else n_pass++;
        @(negedge clk);
        v2 = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit [1:0] hold;
        int g;
        logic [1:0] exp_rdy, exp_v;
        do_reset();
        m_full = 0; m_id = 0; m_ptr = 0; m_res = 32'd0;
        hold = 2'b00;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!hold[i]) begin
                    v2[i]  = ($urandom_range(0, 2) != 0);
                    op2[i] = aluop_e'($urandom_range(0, 15));
                    a2[i]  = ($urandom_range(0, 3) == 0) ? 32'd3 : $urandom;
                    b2[i]  = ($urandom_range(0, 3) == 0) ? 32'd3 : $urandom;
                end
            end
            rr2 = 2'($urandom_range(0, 3));
            #1;
            g = model_grant(v2, rr2);
            exp_rdy = (g >= 0) ? (2'b01 << g) : 2'b00;
            n_total++; if (rdy2 !== exp_rdy) $display("FAIL rnd_req_ready[%0d] got %b want %b", c, rdy2, exp_rdy); else n_pass++;
            @(posedge clk);
            if (g >= 0) begin
                m_full = 1; m_id = g; m_ptr = (g + 1) % 2;
                m_res = ref_alu(int'(op2[g]), a2[g], b2[g]);
            end else if (m_full && rr2[m_id]) begin
                m_full = 0;
            end
            #1;
            exp_v = m_full ? (2'b01 << m_id) : 2'b00;
            n_total++; if (rspv2 !== exp_v) $display("FAIL rnd_rsp_valid[%0d] got %b want %b", c, rspv2, exp_v); else n_pass++;
            n_total++; if (busy2 !== m_full) $display("FAIL rnd_busy[%0d] got %b want %b", c, busy2, m_full); else n_pass++;
            if (m_full) begin
                n_total++; if (res2 !== m_res) $display("FAIL rnd_result[%0d] got %h want %h", c, res2, m_res); else n_pass++;
                n_total++; if (zero2 !== (m_res == 32'd0)) $display("FAIL rnd_zero[%0d] got %b want %b", c, zero2, m_res == 32'd0); else n_pass++;
                n_total++; if (id2 !== 1'(m_id)) $display("FAIL rnd_id[%0d] got %0d want %0d", c, id2, m_id); else n_pass++;
            end
            for (int i = 0; i < 2; i++) hold[i] = v2[i] && (g != i);
            @(negedge clk);
        end
        v2 = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_backpressure();
        test_foreign_ready();
        test_wrap();
        test_reset_mid_full();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
